// File: rtl/spec_free_list_pkg.sv
// Shared rename-stage constants and the release packet carried from the
// architectural map table to the free list.
package spec_free_list_pkg;

   localparam int unsigned FL_PHYS_REGS = 96;
   localparam int unsigned FL_LOG_REGS  = 32;
   localparam int unsigned FL_PHYS_LOG  = 7;
   localparam int unsigned FL_DEPTH     = FL_PHYS_REGS - FL_LOG_REGS;
   localparam int unsigned FL_DEPTH_LOG = 6;
   localparam int unsigned FL_WIDTH     = 4;

   typedef struct packed {
      logic                   valid;
      logic [FL_PHYS_LOG-1:0] tag;
   } release_pkt_t;

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/spec_free_list_sram.sv
// Free-list storage: 4 async read ports, 4 sync write ports, reset image
// holds the physical tags not mapped architecturally (LOG_REGS + index).
module SRAM_4R4W_FREELIST
   import spec_free_list_pkg::*;
#(
   parameter int unsigned DEPTH     = FL_DEPTH,
   parameter int unsigned DEPTH_LOG = FL_DEPTH_LOG,
   parameter int unsigned PHYS_LOG  = FL_PHYS_LOG,
   parameter int unsigned LOG_REGS  = FL_LOG_REGS
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [3:0][DEPTH_LOG-1:0]     raddr_i,
   output logic [3:0][PHYS_LOG-1:0]      rdata_o,
   input  logic [3:0]                    we_i,
   input  logic [3:0][DEPTH_LOG-1:0]     waddr_i,
   input  logic [3:0][PHYS_LOG-1:0]      wdata_i
);

   logic [PHYS_LOG-1:0] mem_q [DEPTH];

   // Write addresses come from the compaction network and never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem_q[i] <= PHYS_LOG'(LOG_REGS + i);
      end else begin
         for (int unsigned k = 0; k < 4; k++)
            if (we_i[k]) mem_q[waddr_i[k]] <= wdata_i[k];
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < 4; k++)
         rdata_o[k] = mem_q[raddr_i[k]];
   end

endmodule

// File: rtl/spec_free_list.sv
// Speculative free list: hands four free tags per cycle to rename, compacts up
// to four released tags per cycle, and recovers by snapping head to tail.
module spec_free_list
   import spec_free_list_pkg::*;
#(
   parameter int unsigned PHYS_REGS = FL_PHYS_REGS,
   parameter int unsigned LOG_REGS  = FL_LOG_REGS,
   parameter int unsigned PHYS_LOG  = FL_PHYS_LOG,
   parameter int unsigned DEPTH     = FL_DEPTH,
   parameter int unsigned DEPTH_LOG = FL_DEPTH_LOG,
   parameter int unsigned WIDTH     = FL_WIDTH
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 reqFreeReg_i,
   input  logic                 recoverFlag_i,
   input  logic                 releasedValid0_i,
   input  logic                 releasedValid1_i,
   input  logic                 releasedValid2_i,
   input  logic                 releasedValid3_i,
   input  logic [PHYS_LOG-1:0]  releasedPhyMap0_i,
   input  logic [PHYS_LOG-1:0]  releasedPhyMap1_i,
   input  logic [PHYS_LOG-1:0]  releasedPhyMap2_i,
   input  logic [PHYS_LOG-1:0]  releasedPhyMap3_i,
   output logic [PHYS_LOG-1:0]  freedPhyReg0_o,
   output logic [PHYS_LOG-1:0]  freedPhyReg1_o,
   output logic [PHYS_LOG-1:0]  freedPhyReg2_o,
   output logic [PHYS_LOG-1:0]  freedPhyReg3_o,
   output logic                 freeListEmpty_o,
   output logic [DEPTH_LOG:0]   freeCount_o
);

   localparam int unsigned CW = DEPTH_LOG + 2;
   localparam logic CFG_OK = (DEPTH == PHYS_REGS - LOG_REGS) && (WIDTH == 4)
                             && ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH == (1 << DEPTH_LOG));

   release_pkt_t                 rel [4];
   logic [3:0]                   rv;
   logic [2:0]                   off [4];
   logic [2:0]                   n_rel;
   logic                         pop;
   logic [DEPTH_LOG-1:0]         head_q, head_d, tail_q, tail_d;
   logic [DEPTH_LOG:0]           count_q, count_d;
   logic [CW-1:0]                count_sum;
   logic [3:0][DEPTH_LOG-1:0]    raddr, waddr;
   logic [3:0][PHYS_LOG-1:0]     rdata, wdata;

   always_comb begin
      rel[0] = '{valid: releasedValid0_i, tag: releasedPhyMap0_i};
      rel[1] = '{valid: releasedValid1_i, tag: releasedPhyMap1_i};
      rel[2] = '{valid: releasedValid2_i, tag: releasedPhyMap2_i};
      rel[3] = '{valid: releasedValid3_i, tag: releasedPhyMap3_i};
   end

   // Exclusive prefix popcount: slot k lands at tail + (valid slots below k).
   always_comb begin
      off[0] = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         rv[k]    = rel[k].valid;
         wdata[k] = rel[k].tag;
         raddr[k] = head_q + DEPTH_LOG'(k);
         if (k > 0) off[k] = off[k-1] + 3'(rel[k-1].valid);
         waddr[k] = tail_q + DEPTH_LOG'(off[k]);
      end
   end

   assign n_rel = popcnt4(rv);
   assign pop   = reqFreeReg_i & ~freeListEmpty_o & ~recoverFlag_i;

   always_comb begin
      tail_d    = tail_q + DEPTH_LOG'(n_rel);
      count_sum = CW'(count_q) - (pop ? CW'(WIDTH) : '0) + CW'(n_rel);
      head_d    = head_q + (pop ? DEPTH_LOG'(WIDTH) : '0);
      count_d   = count_sum[DEPTH_LOG:0];
      if (recoverFlag_i) begin
         head_d  = tail_d;
         count_d = (DEPTH_LOG+1)'(DEPTH);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= (DEPTH_LOG+1)'(DEPTH);
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         assert (CFG_OK);
         if (!recoverFlag_i) assert (count_sum <= CW'(DEPTH));
      end
   end

   SRAM_4R4W_FREELIST #(
      .DEPTH     (DEPTH),
      .DEPTH_LOG (DEPTH_LOG),
      .PHYS_LOG  (PHYS_LOG),
      .LOG_REGS  (LOG_REGS)
   ) u_sram (
      .clk     (clk),
      .reset   (reset),
      .raddr_i (raddr),
      .rdata_o (rdata),
      .we_i    (rv),
      .waddr_i (waddr),
      .wdata_i (wdata)
   );

   assign freedPhyReg0_o  = rdata[0];
   assign freedPhyReg1_o  = rdata[1];
   assign freedPhyReg2_o  = rdata[2];
   assign freedPhyReg3_o  = rdata[3];
   assign freeListEmpty_o = (count_q < (DEPTH_LOG+1)'(WIDTH));
   assign freeCount_o     = count_q;

endmodule

// File: tb/tb_spec_free_list.sv
// Directed bench for spec_free_list: reset image, drain, compaction,
// recovery (with and without releases) and pointer wrap.
module tb_spec_free_list;

   logic       clk = 1'b0;
   logic       reset, reqFreeReg, recoverFlag;
   logic [3:0] rv;
   logic [6:0] rt0, rt1, rt2, rt3;
   logic [6:0] f0, f1, f2, f3;
   logic       empty;
   logic [6:0] count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   spec_free_list dut (
      .clk               (clk),
      .reset             (reset),
      .reqFreeReg_i      (reqFreeReg),
      .recoverFlag_i     (recoverFlag),
      .releasedValid0_i  (rv[0]),
      .releasedValid1_i  (rv[1]),
      .releasedValid2_i  (rv[2]),
      .releasedValid3_i  (rv[3]),
      .releasedPhyMap0_i (rt0),
      .releasedPhyMap1_i (rt1),
      .releasedPhyMap2_i (rt2),
      .releasedPhyMap3_i (rt3),
      .freedPhyReg0_o    (f0),
      .freedPhyReg1_o    (f1),
      .freedPhyReg2_o    (f2),
      .freedPhyReg3_o    (f3),
      .freeListEmpty_o   (empty),
      .freeCount_o       (count)
   );

   task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rel(input logic [3:0] v, input logic [6:0] t0, input logic [6:0] t1,
                          input logic [6:0] t2, input logic [6:0] t3);
      rv = v; rt0 = t0; rt1 = t1; rt2 = t2; rt3 = t3;
   endtask

   task automatic chk_out(input string tag, input int unsigned e0, input int unsigned e1,
                          input int unsigned e2, input int unsigned e3);
      check_eq({tag, ".f0"}, f0, e0);
      check_eq({tag, ".f1"}, f1, e1);
      check_eq({tag, ".f2"}, f2, e2);
      check_eq({tag, ".f3"}, f3, e3);
   endtask

   task automatic chk_cnt(input string tag, input int unsigned c, input int unsigned e);
      check_eq({tag, ".count"}, count, c);
      check_eq({tag, ".empty"}, empty, e);
   endtask

   task automatic do_reset();
      reset = 1'b1; reqFreeReg = 1'b0; recoverFlag = 1'b0;
      set_rel(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic alloc(input int unsigned n);
      reqFreeReg = 1'b1;
      for (int unsigned i = 0; i < n; i++) tick();
      reqFreeReg = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk_out("reset", 32, 33, 34, 35);
      chk_cnt("reset", 64, 0);

      // Drain all 64 entries four at a time.
      reqFreeReg = 1'b1;
      for (int unsigned g = 0; g < 16; g++) begin
         chk_out($sformatf("drain%0d", g), 32+4*g, 33+4*g, 34+4*g, 35+4*g);
         check_eq($sformatf("drain%0d.count", g), count, 64-4*g);
         tick();
      end
      chk_cnt("drained", 0, 1);
      tick();
      reqFreeReg = 1'b0;
      chk_cnt("req_empty", 0, 1);
      chk_out("req_empty", 32, 33, 34, 35);

      // Compaction: slot 1 invalid with a junk tag must not be written.
      set_rel(4'b1101, 7'd5, 7'd77, 7'd9, 7'd12);
      tick();
      set_rel(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
      chk_cnt("compact", 3, 1);
      chk_out("compact", 5, 9, 12, 35);
      set_rel(4'b0001, 7'd20, 7'd0, 7'd0, 7'd0);
      tick();
      set_rel(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
      chk_cnt("compact4", 4, 0);
      chk_out("compact4", 5, 9, 12, 20);

      // Recovery with request held high: allocation must be suppressed.
      do_reset();
      alloc(3);
      chk_cnt("pre_rec", 52, 0);
      chk_out("pre_rec", 44, 45, 46, 47);
      recoverFlag = 1'b1; reqFreeReg = 1'b1;
      tick();
      recoverFlag = 1'b0; reqFreeReg = 1'b0;
      chk_cnt("recover", 64, 0);
      chk_out("recover", 32, 33, 34, 35);

      // Recovery with two concurrent releases.
      do_reset();
      alloc(3);
      recoverFlag = 1'b1;
      set_rel(4'b0011, 7'd40, 7'd41, 7'd0, 7'd0);
      tick();
      recoverFlag = 1'b0;
      set_rel(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
      chk_cnt("rec_rel", 64, 0);
      chk_out("rec_rel", 34, 35, 36, 37);

      // Wrap: head 60, entries 0..3 refilled with 7..10.
      do_reset();
      alloc(15);
      chk_cnt("wrap_setup", 4, 0);
      set_rel(4'b1111, 7'd7, 7'd8, 7'd9, 7'd10);
      tick();
      chk_cnt("wrap_fill", 8, 0);
      chk_out("wrap_fill", 92, 93, 94, 95);
      reqFreeReg = 1'b1;
      set_rel(4'b1111, 7'd50, 7'd51, 7'd52, 7'd53);
      chk_out("wrap_c1", 92, 93, 94, 95);
      tick();
      set_rel(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
      chk_cnt("wrap_c1", 8, 0);
      chk_out("wrap_c2", 7, 8, 9, 10);
      tick();
      reqFreeReg = 1'b0;
      chk_cnt("wrap_c2", 4, 0);
      chk_out("wrap_c3", 50, 51, 52, 53);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
